// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, register-file write port
// generation, misaligned-load detection and a retired-instruction counter.
module mem_wb_stage #(
    parameter bit COUNT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        reg_write_i,
    input  logic [4:0]  rd_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] load_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [4:0]  rd,
    output logic [31:0] rd_wr_data,
    output logic        rd_wr_en,
    output logic        load_misaligned,
    output logic [31:0] instret
);

    // Handshake: valid_i qualifies the MEM-stage entry; it is captured on every
    // rising edge with stall_i low. stall_i high freezes the WB entry (fresh
    // drops so side effects fire once per entry); flush_i kills the entry being
    // captured and wins over stall_i.
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    logic        valid_q;
    logic        fresh_q;
    logic        reg_write_q;
    logic [4:0]  rd_q;
    logic [1:0]  wb_sel_q;
    logic [31:0] alu_result_q;
    logic [2:0]  funct3_q;
    logic [31:0] pc_plus4_q;
    logic [31:0] load_data_q;

    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic        is_load;
    logic        misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            fresh_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= 5'd0;
            wb_sel_q     <= WB_ALU;
            alu_result_q <= 32'h0;
        end else if (flush_i && stall_i) begin
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
        end else if (!stall_i) begin
            valid_q      <= valid_i & ~flush_i;
            fresh_q      <= 1'b1;
            reg_write_q  <= reg_write_i;
            rd_q         <= rd_i;
            wb_sel_q     <= wb_sel_i;
            alu_result_q <= alu_result_i;
        end else begin
            fresh_q <= 1'b0;
        end
    end

    // Pure datapath fields: no reset needed, they are only observed behind valid.
    always_ff @(posedge clk) begin
        if (!stall_i) begin
            funct3_q    <= funct3_i;
            pc_plus4_q  <= pc_plus4_i;
            load_data_q <= load_data_i;
        end
    end

    always_comb begin
        off = alu_result_q[1:0];
        case (off)
            2'd0:    byte_sel = load_data_q[7:0];
            2'd1:    byte_sel = load_data_q[15:8];
            2'd2:    byte_sel = load_data_q[23:16];
            default: byte_sel = load_data_q[31:24];
        endcase
        half_sel = off[1] ? load_data_q[31:16] : load_data_q[15:0];

        case (funct3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = load_data_q;
        endcase

        is_load = (wb_sel_q == WB_LOAD);
        case (funct3_q)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = is_load & off[0];
            default:        misaligned = is_load & (off != 2'd0);
        endcase
    end

    always_comb begin
        rd = rd_q;
        case (wb_sel_q)
            WB_ALU:  rd_wr_data = alu_result_q;
            WB_LOAD: rd_wr_data = load_val;
            WB_PC4:  rd_wr_data = pc_plus4_q;
            default: rd_wr_data = 32'h0;
        endcase
        rd_wr_en        = valid_q & reg_write_q & (rd_q != 5'd0) & ~misaligned;
        load_misaligned = valid_q & fresh_q & misaligned;
    end

    generate
        if (COUNT_EN) begin : g_instret
            logic [31:0] instret_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    instret_q <= 32'h0;
                end else if (valid_q && fresh_q) begin
                    instret_q <= instret_q + 32'd1;
                end
            end
            assign instret = instret_q;
        end else begin : g_no_instret
            assign instret = 32'h0;
        end
    endgenerate

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed literal cases plus randomized traffic
// checked every cycle against an entry-level behavioural model.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        reg_write_i;
    logic [4:0]  rd_i;
    logic [1:0]  wb_sel_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_result_i;
    logic [31:0] pc_plus4_i;
    logic [31:0] load_data_i;
    logic        stall_i;
    logic        flush_i;

    logic [4:0]  rd;
    logic [31:0] rd_wr_data;
    logic        rd_wr_en;
    logic        load_misaligned;
    logic [31:0] instret;

    logic [4:0]  rd_nc;
    logic [31:0] rd_wr_data_nc;
    logic        rd_wr_en_nc;
    logic        load_misaligned_nc;
    logic [31:0] instret_nc;

    int n_cmp;
    int n_err;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_wb_stage #(.COUNT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .reg_write_i(reg_write_i),
        .rd_i(rd_i), .wb_sel_i(wb_sel_i), .funct3_i(funct3_i),
        .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i),
        .load_data_i(load_data_i), .stall_i(stall_i), .flush_i(flush_i),
        .rd(rd), .rd_wr_data(rd_wr_data), .rd_wr_en(rd_wr_en),
        .load_misaligned(load_misaligned), .instret(instret)
    );

    mem_wb_stage #(.COUNT_EN(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .valid_i(valid_i), .reg_write_i(reg_write_i),
        .rd_i(rd_i), .wb_sel_i(wb_sel_i), .funct3_i(funct3_i),
        .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i),
        .load_data_i(load_data_i), .stall_i(stall_i), .flush_i(flush_i),
        .rd(rd_nc), .rd_wr_data(rd_wr_data_nc), .rd_wr_en(rd_wr_en_nc),
        .load_misaligned(load_misaligned_nc), .instret(instret_nc)
    );

    // ---------------- behavioural model ----------------
    // The model holds "the instruction currently in writeback" and derives
    // every output from its fields with plain arithmetic.
    logic        m_valid;
    logic        m_fresh;
    logic        m_pristine;
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    logic [31:0] m_alu;
    logic [31:0] m_pc;
    logic [31:0] m_ld;
    logic [31:0] m_instret;

    task automatic model_reset();
        m_valid    = 1'b0;
        m_fresh    = 1'b0;
        m_pristine = 1'b1;
        m_rw       = 1'b0;
        m_rd       = 5'd0;
        m_sel      = 2'd0;
        m_alu      = 32'h0;
        m_instret  = 32'h0;
    endtask

    task automatic model_step();
        if (m_valid && m_fresh) m_instret = m_instret + 32'd1;
        if (stall_i) begin
            m_fresh = 1'b0;
            if (flush_i) m_valid = 1'b0;
        end else begin
            m_valid    = valid_i && !flush_i;
            m_fresh    = 1'b1;
            m_pristine = 1'b0;
            m_rw       = reg_write_i;
            m_rd       = rd_i;
            m_sel      = wb_sel_i;
            m_f3       = funct3_i;
            m_alu      = alu_result_i;
            m_pc       = pc_plus4_i;
            m_ld       = load_data_i;
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic exp_mis();
        return (m_sel == 2'd1) && ((m_alu % access_size(m_f3)) != 0);
    endfunction

    function automatic logic [31:0] exp_data();
        int          off;
        logic [31:0] w;
        logic [31:0] r;
        off = int'(m_alu[1:0]);
        r   = 32'h0;
        case (m_sel)
            2'd0: r = m_alu;
            2'd2: r = m_pc;
            2'd1: begin
                case (access_size(m_f3))
                    1: w = (m_ld >> (8 * off)) & 32'hFF;
                    2: w = (m_ld >> (16 * (off / 2))) & 32'hFFFF;
                    default: w = m_ld;
                endcase
                r = w;
                if (m_f3 == 3'd0 && w >= 32'h80)   r = w - 32'h100;
                if (m_f3 == 3'd1 && w >= 32'h8000) r = w - 32'h10000;
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: every falling edge, DUT vs model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_en", {31'h0, rd_wr_en}, 32'h0);
            chk("rst_lm", {31'h0, load_misaligned}, 32'h0);
            chk("rst_instret", instret, 32'h0);
            chk("rst_rd", {27'h0, rd}, 32'h0);
        end else begin
            chk("cyc_en", {31'h0, rd_wr_en},
                {31'h0, m_valid && m_rw && (m_rd != 5'd0) && !exp_mis()});
            chk("cyc_lm", {31'h0, load_misaligned},
                {31'h0, m_valid && m_fresh && exp_mis()});
            chk("cyc_instret", instret, m_instret);
            if (m_valid) begin
                chk("cyc_rd", {27'h0, rd}, {27'h0, m_rd});
                chk("cyc_data", rd_wr_data, exp_data());
            end
            if (m_pristine) chk("cyc_data_idle", rd_wr_data, 32'h0);
        end
        chk("nocount_instret", instret_nc, 32'h0);
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic v, input logic rw, input logic [4:0] r,
                          input logic [1:0] sel, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] pc,
                          input logic [31:0] ld, input logic st, input logic fl);
        valid_i = v; reg_write_i = rw; rd_i = r; wb_sel_i = sel; funct3_i = f3;
        alu_result_i = alu; pc_plus4_i = pc; load_data_i = ld;
        stall_i = st; flush_i = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic [2:0] f3_tab [5];
    logic [31:0] base;

    initial begin
        n_cmp = 0;
        n_err = 0;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst = 1'b0;
        model_reset();
        set_in(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // Reset state, before any capture.
        @(posedge clk); #1;
        chk("reset_en", {31'h0, rd_wr_en}, 32'h0);
        chk("reset_instret", instret, 32'h0);
        chk("reset_data", rd_wr_data, 32'h0);
        chk("reset_rd", {27'h0, rd}, 32'h0);
        model_step();

        // ALU write.
        set_in(1, 1, 5'd5, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, 0); tick();
        chk("alu_rd", {27'h0, rd}, 32'd5);
        chk("alu_data", rd_wr_data, 32'h1234);
        chk("alu_en", {31'h0, rd_wr_en}, 32'h1);
        idle();
        chk("alu_instret", instret, 32'd1);

        // Load extraction.
        set_in(1, 1, 5'd3, 2'd1, 3'd0, 32'h3, 32'h0, 32'h80FF_0000, 0, 0); tick();
        chk("lb_off3", rd_wr_data, 32'hFFFF_FF80);
        set_in(1, 1, 5'd3, 2'd1, 3'd4, 32'h3, 32'h0, 32'h80FF_0000, 0, 0); tick();
        chk("lbu_off3", rd_wr_data, 32'h0000_0080);
        set_in(1, 1, 5'd3, 2'd1, 3'd5, 32'h2, 32'h0, 32'h80FF_0000, 0, 0); tick();
        chk("lhu_off2", rd_wr_data, 32'h0000_80FF);

        // Misaligned LW: pulse once, no write, still retires.
        idle();
        base = instret;
        set_in(1, 1, 5'd4, 2'd1, 3'd2, 32'h1002, 32'h0, 32'h0, 0, 0); tick();
        chk("lw_mis_en", {31'h0, rd_wr_en}, 32'h0);
        chk("lw_mis_pulse", {31'h0, load_misaligned}, 32'h1);
        set_in(1, 1, 5'd4, 2'd1, 3'd2, 32'h1002, 32'h0, 32'h0, 1, 0); tick();
        chk("lw_mis_pulse_end", {31'h0, load_misaligned}, 32'h0);
        idle();
        chk("lw_mis_instret", instret, base + 32'd1);

        // rd=0 and JAL link.
        set_in(1, 1, 5'd0, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0, 0, 0); tick();
        chk("rd0_en", {31'h0, rd_wr_en}, 32'h0);
        set_in(1, 1, 5'd1, 2'd2, 3'd0, 32'h0, 32'h104, 32'h0, 0, 0); tick();
        chk("jal_data", rd_wr_data, 32'h104);
        chk("jal_en", {31'h0, rd_wr_en}, 32'h1);

        // Three-cycle stall on a valid entry, then flush under stall.
        idle();
        base = instret;
        set_in(1, 1, 5'd7, 2'd0, 3'd0, 32'hAA, 32'h0, 32'h0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 5'd9, 2'd0, 3'd0, 32'hBB, 32'h0, 32'h0, 1, 0); tick();
            chk("stall_en", {31'h0, rd_wr_en}, 32'h1);
            chk("stall_data", rd_wr_data, 32'hAA);
            chk("stall_rd", {27'h0, rd}, 32'd7);
        end
        chk("stall_instret", instret, base + 32'd1);
        set_in(1, 1, 5'd9, 2'd0, 3'd0, 32'hBB, 32'h0, 32'h0, 1, 1); tick();
        chk("stall_flush_en", {31'h0, rd_wr_en}, 32'h0);
        idle();

        // Asynchronous reset with instret at 7.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(1, 1, 5'd9, 2'd0, 3'd0, 32'h10 + i, 32'h0, 32'h0, 0, 0); tick();
        end
        set_in(1, 1, 5'd9, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0, 1, 0); tick();
        chk("pre_rst_instret", instret, 32'd7);
        chk("pre_rst_en", {31'h0, rd_wr_en}, 32'h1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_en", {31'h0, rd_wr_en}, 32'h0);
        chk("async_rst_instret", instret, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            set_in(1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 4) != 0),
                   ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   2'($urandom_range(0, 3)),
                   f3_tab[$urandom_range(0, 4)],
                   $urandom(), $urandom(), $urandom(),
                   1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 7) == 0));
            tick();
        end
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: COUNT_EN, 1, enables the retired-instruction counter; when 0, instret SHALL stay 0.
REQ-002 Port: clk  in  1  pipeline clock, all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: valid_i  in  1  MEM stage presents an instruction this cycle.
REQ-005 Port: reg_write_i  in  1  instruction writes a destination register.
REQ-006 Port: rd_i  in  5  destination register index.
REQ-007 Port: wb_sel_i  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-008 Port: funct3_i  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 Port: alu_result_i  in  32  ALU result; bits [1:0] are the load byte offset.
REQ-010 Port: pc_plus4_i  in  32  link value for JAL/JALR.
REQ-011 Port: load_data_i  in  32  raw aligned word from data memory.
REQ-012 Port: stall_i  in  1  freeze the WB register.
REQ-013 Port: flush_i  in  1  kill the entry being captured.
REQ-014 Port: rd  out  5  register-file write index.
REQ-015 Port: rd_wr_data  out  32  register-file write data.
REQ-016 Port: rd_wr_en  out  1  register-file write enable.
REQ-017 Port: load_misaligned  out  1  one-cycle pulse on a misaligned load entering WB.
REQ-018 Port: instret  out  32  count of retired instructions.

Function
REQ-019 WB register fields: valid, reg_write, rd, wb_sel, funct3, alu_result, pc_plus4, load_data, fresh.
REQ-020 Capture at each rising edge when stall_i=0: fields <= inputs, valid <= valid_i & ~flush_i, fresh <= 1.
REQ-021 stall_i=1 and flush_i=0: all fields hold; fresh <= 0.
REQ-022 flush_i=1 overrides stall_i: valid <= 0 regardless of stall_i; other fields don't-care.
REQ-023 Latency: inputs at edge N appear on rd/rd_wr_data/rd_wr_en after edge N; outputs are combinational from the WB register only.
REQ-024 Load extraction: byte = load_data[8*off+7:8*off], half = load_data[16*off[1]+15:16*off[1]], off = alu_result[1:0].
REQ-025 LB/LH sign-extend, LBU/LHU zero-extend, LW passes word; undefined funct3 with wb_sel=01 yields LW behaviour.
REQ-026 rd_wr_data: ALU -> alu_result; load -> extracted value; PC+4 -> pc_plus4; 11 -> 32'h0.
REQ-027 Misaligned: load with LH/LHU and off[0]=1, or LW and off!=0.
REQ-028 rd_wr_en = valid & reg_write & (rd!=0) & ~misaligned; held high through stall (idempotent rewrite).
REQ-029 rd output equals registered rd even when rd_wr_en=0.
REQ-030 load_misaligned = valid & fresh & misaligned & (wb_sel==01); asserts exactly one cycle per entry.
REQ-031 instret increments by 1 at the edge following a cycle with valid & fresh (misaligned, rd=0 and reg_write=0 entries included); never twice per entry.
REQ-032 instret wraps 32'hFFFFFFFF -> 0 silently.

Reset
REQ-033 rst low asynchronously clears valid, fresh, reg_write, rd, and instret; rd_wr_en and load_misaligned SHALL be 0 during reset.
REQ-034 Reset mid-stall discards the held entry; first capture after rst release behaves as REQ-020.
REQ-035 Datapath fields need no reset; rd_wr_data SHALL still read 32'h0 while valid=0 and wb_sel register is reset to 00 with alu_result reset to 0.

Verification
REQ-036 ALU: valid, reg_write, rd=5, wb_sel=00, alu=32'h1234 -> next cycle rd=5, rd_wr_data=32'h1234, rd_wr_en=1, instret=1 one cycle later.
REQ-037 LB off=3, load_data=32'h80FF_0000 -> rd_wr_data=32'hFFFFFF80; same with LBU -> 32'h00000080; LHU off=2 -> 32'h000080FF.
REQ-038 LW with alu=32'h1002 -> rd_wr_en=0, load_misaligned one-cycle pulse, instret still +1.
REQ-039 rd=0 with reg_write=1 -> rd_wr_en=0; JAL wb_sel=10, pc_plus4=32'h104, rd=1 -> rd_wr_data=32'h104, rd_wr_en=1.
REQ-040 Stall 3 cycles on valid entry -> outputs held, rd_wr_en high all 3 cycles, instret +1 only; flush_i with stall_i -> rd_wr_en=0 next cycle.
REQ-041 Assert rst low mid-stream with instret=7 -> rd_wr_en=0 and instret=0 immediately, before next clock edge.
